// File: rtl/urna_eletronica.sv
// ---------------------------------------------------------------------------
// urna_eletronica -- ballot-box controller for a five-way tally.
//
// A voter enters a four-digit BCD candidate code one digit per `valid`
// strobe. A further strobe either confirms the vote (confirma=1) or cancels
// it (confirma=0). A confirmed vote produces a one-clock pulse on exactly one
// candidate output. The candidate outputs drive external rising-edge BCD
// counters, so they come straight from flops and cannot glitch.
//
// Handshake: `valid` is an edge-triggered strobe, not a valid/ready pair.
// Each low-to-high transition of `valid` that is sampled on a rising clock
// edge counts as exactly one entry. How long `valid` stays high does not
// matter. There is no ready/back-pressure signal: an entry that arrives
// while the machine cannot use it is simply dropped. Such entries are a
// non-BCD digit, any strobe in VOTE, and any strobe in DONE.
//
// Ports
//   clock            system clock, all state changes on its rising edge
//   reset            synchronous, active-high; clears FSM, digits, outputs
//   digit[3:0]       BCD digit presented together with `valid`
//   valid            entry strobe (acts on its rising edge)
//   confirma         level, sampled on a `valid` edge while in CONF
//   finish           level, closes the election
//   estado[2:0]      current state code (debug / observation)
//   next_estado[2:0] combinational next state, reset included
//   digito1..4[3:0]  digits entered (digito1 is the most significant)
//   votoValido[1:0]  00 none/in progress, 01 candidate, 10 null, 11 closed
//   candidato*       one-clock vote pulses, high only during VOTE
// ---------------------------------------------------------------------------
module urna_eletronica #(
  parameter logic [15:0] COD_ARTHUR  = 16'h3503,
  parameter logic [15:0] COD_LEANDRO = 16'h3489,
  parameter logic [15:0] COD_MATEUS  = 16'h3513,
  parameter logic [15:0] COD_PABLO   = 16'h3527
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       valid,
  input  logic       confirma,
  input  logic       finish,
  output logic [2:0] estado,
  output logic [2:0] next_estado,
  output logic [3:0] digito1,
  output logic [3:0] digito2,
  output logic [3:0] digito3,
  output logic [3:0] digito4,
  output logic [1:0] votoValido,
  output logic       candidatoArthur,
  output logic       candidatoLeandro,
  output logic       candidatoMateus,
  output logic       candidatoPablo,
  output logic       candidatoNulo
);

  typedef enum logic [2:0] {
    S_D1   = 3'd0,
    S_D2   = 3'd1,
    S_D3   = 3'd2,
    S_D4   = 3'd3,
    S_CONF = 3'd4,
    S_VOTE = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [1:0] VOTO_NONE   = 2'b00;
  localparam logic [1:0] VOTO_CAND   = 2'b01;
  localparam logic [1:0] VOTO_NULO   = 2'b10;
  localparam logic [1:0] VOTO_CLOSED = 2'b11;

  state_t state_q;
  state_t state_d;

  logic valid_q;
  logic vedge;
  logic digit_ok;

  // Registered every cycle, including during reset. A `valid` held high
  // across reset release therefore produces no edge.
  always_ff @(posedge clock) begin
    valid_q <= valid;
  end

  assign vedge    = valid & ~valid_q;
  assign digit_ok = (digit <= 4'd9);

  // Code that will be complete once the fourth digit is latched. It is used
  // to grade the vote on the D4 -> CONF transition.
  logic [15:0] code_entering;
  logic [15:0] code_held;
  logic        entering_is_cand;

  assign code_entering = {digito1, digito2, digito3, digit};
  assign code_held     = {digito1, digito2, digito3, digito4};

  assign entering_is_cand = (code_entering == COD_ARTHUR)  ||
                            (code_entering == COD_LEANDRO) ||
                            (code_entering == COD_MATEUS)  ||
                            (code_entering == COD_PABLO);

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = S_D1;
    end else begin
      case (state_q)
        S_D1, S_D2, S_D3, S_D4: begin
          if (finish) begin
            state_d = S_DONE;
          end else if (vedge && digit_ok) begin
            case (state_q)
              S_D1:    state_d = S_D2;
              S_D2:    state_d = S_D3;
              S_D3:    state_d = S_D4;
              default: state_d = S_CONF;
            endcase
          end
        end
        S_CONF: begin
          if (finish) begin
            state_d = S_DONE;
          end else if (vedge) begin
            state_d = confirma ? S_VOTE : S_D1;
          end
        end
        // The pulse has been emitted during this cycle. A finish seen here
        // closes the election on the following edge instead of cutting it.
        S_VOTE:  state_d = finish ? S_DONE : S_D1;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_D1;   // unused code 7
      endcase
    end
  end

  assign estado      = state_q;
  assign next_estado = state_d;

  // Transition qualifiers, derived from the next-state decision so that
  // datapath and FSM can never disagree.
  logic take_digit;
  logic enter_conf;
  logic cancel_vote;
  logic enter_vote;
  logic enter_done;

  assign take_digit  = (state_q <= S_D4) && (state_d != state_q) && (state_d != S_DONE);
  assign enter_conf  = (state_q == S_D4)   && (state_d == S_CONF);
  assign cancel_vote = (state_q == S_CONF) && (state_d == S_D1);
  assign enter_vote  = (state_q == S_CONF) && (state_d == S_VOTE);
  assign enter_done  = (state_q != S_DONE) && (state_d == S_DONE);

  // ---------------- state, digits, grading, pulses ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_D1;
      digito1          <= 4'd0;
      digito2          <= 4'd0;
      digito3          <= 4'd0;
      digito4          <= 4'd0;
      votoValido       <= VOTO_NONE;
      candidatoArthur  <= 1'b0;
      candidatoLeandro <= 1'b0;
      candidatoMateus  <= 1'b0;
      candidatoPablo   <= 1'b0;
      candidatoNulo    <= 1'b0;
    end else begin
      state_q <= state_d;

      // Pulses last one cycle: cleared by default, set only on CONF -> VOTE.
      candidatoArthur  <= 1'b0;
      candidatoLeandro <= 1'b0;
      candidatoMateus  <= 1'b0;
      candidatoPablo   <= 1'b0;
      candidatoNulo    <= 1'b0;

      if (take_digit) begin
        case (state_q)
          S_D1: begin
            digito1    <= digit;
            votoValido <= VOTO_NONE;  // previous vote's grade is dropped
          end
          S_D2:    digito2 <= digit;
          S_D3:    digito3 <= digit;
          default: digito4 <= digit;
        endcase
      end

      if (enter_conf) begin
        votoValido <= entering_is_cand ? VOTO_CAND : VOTO_NULO;
      end

      if (cancel_vote) begin
        digito1    <= 4'd0;
        digito2    <= 4'd0;
        digito3    <= 4'd0;
        digito4    <= 4'd0;
        votoValido <= VOTO_NONE;
      end

      if (enter_vote) begin
        if (code_held == COD_ARTHUR)       candidatoArthur  <= 1'b1;
        else if (code_held == COD_LEANDRO) candidatoLeandro <= 1'b1;
        else if (code_held == COD_MATEUS)  candidatoMateus  <= 1'b1;
        else if (code_held == COD_PABLO)   candidatoPablo   <= 1'b1;
        else                               candidatoNulo    <= 1'b1;
      end

      if (enter_done) begin
        votoValido <= VOTO_CLOSED;
      end
    end
  end

endmodule

// File: tb/tb_urna_eletronica.sv
// ---------------------------------------------------------------------------
// tb_urna_eletronica -- directed bench for urna_eletronica.
// Inputs change 1 time unit after a falling edge. The reference model steps
// on each rising edge, and the DUT is compared with it on each falling edge.
// ---------------------------------------------------------------------------
module tb_urna_eletronica;

  logic       clock;
  logic       reset;
  logic [3:0] digit;
  logic       valid;
  logic       confirma;
  logic       finish;
  logic [2:0] estado;
  logic [2:0] next_estado;
  logic [3:0] digito1, digito2, digito3, digito4;
  logic [1:0] votoValido;
  logic       candidatoArthur, candidatoLeandro, candidatoMateus;
  logic       candidatoPablo, candidatoNulo;

  urna_eletronica dut (
    .clock            (clock),
    .reset            (reset),
    .digit            (digit),
    .valid            (valid),
    .confirma         (confirma),
    .finish           (finish),
    .estado           (estado),
    .next_estado      (next_estado),
    .digito1          (digito1),
    .digito2          (digito2),
    .digito3          (digito3),
    .digito4          (digito4),
    .votoValido       (votoValido),
    .candidatoArthur  (candidatoArthur),
    .candidatoLeandro (candidatoLeandro),
    .candidatoMateus  (candidatoMateus),
    .candidatoPablo   (candidatoPablo),
    .candidatoNulo    (candidatoNulo)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;
  int pulse_cnt[5];  // arthur, leandro, mateus, pablo, nulo

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // State numbers: 0..3 collecting digit n+1, 4 awaiting confirm,
  // 5 vote pulse, 6 closed.
  logic [15:0] codes[4] = '{16'h3503, 16'h3489, 16'h3513, 16'h3527};
  int m_state = 0;
  int m_dig[4] = '{0, 0, 0, 0};
  int m_voto = 0;
  int m_pulse = -1;     // index of candidate expected high, -1 none
  bit m_vprev = 0;

  function automatic int who(input int d0, input int d1, input int d2, input int d3);
    logic [15:0] c;
    c = {d0[3:0], d1[3:0], d2[3:0], d3[3:0]};
    for (int i = 0; i < 4; i++) if (codes[i] == c) return i;
    return 4;
  endfunction

  function automatic int model_next(input int s, input bit rst, input bit e,
                                    input int d, input bit c, input bit f);
    if (rst) return 0;
    if (s == 6) return 6;
    if (s == 5) return f ? 6 : 0;
    if (f) return 6;
    if (!e) return s;
    if (s <= 3) return (d <= 9) ? s + 1 : s;
    return c ? 5 : 0;
  endfunction

  task automatic model_step();
    bit e;
    int nxt;
    e = valid && !m_vprev;
    m_vprev = valid;
    nxt = model_next(m_state, reset, e, int'(digit), confirma, finish);
    m_pulse = -1;
    if (reset) begin
      m_dig = '{0, 0, 0, 0};
      m_voto = 0;
    end else begin
      if (m_state <= 3 && nxt == m_state + 1) begin
        m_dig[m_state] = int'(digit);
        if (m_state == 0) m_voto = 0;
        if (m_state == 3) m_voto = (who(m_dig[0], m_dig[1], m_dig[2], m_dig[3]) < 4) ? 1 : 2;
      end
      if (m_state == 4 && nxt == 0) begin
        m_dig = '{0, 0, 0, 0};
        m_voto = 0;
      end
      if (nxt == 5) m_pulse = who(m_dig[0], m_dig[1], m_dig[2], m_dig[3]);
      if (nxt == 6 && m_state != 6) m_voto = 3;
    end
    m_state = nxt;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clock);
    if (check_en) begin
      chk("estado", int'(estado), m_state);
      chk("next_estado", int'(next_estado),
          model_next(m_state, reset, valid && !m_vprev, int'(digit), confirma, finish));
      chk("digito1", int'(digito1), m_dig[0]);
      chk("digito2", int'(digito2), m_dig[1]);
      chk("digito3", int'(digito3), m_dig[2]);
      chk("digito4", int'(digito4), m_dig[3]);
      chk("votoValido", int'(votoValido), m_voto);
      chk("candidatoArthur",  int'(candidatoArthur),  int'(m_pulse == 0));
      chk("candidatoLeandro", int'(candidatoLeandro), int'(m_pulse == 1));
      chk("candidatoMateus",  int'(candidatoMateus),  int'(m_pulse == 2));
      chk("candidatoPablo",   int'(candidatoPablo),   int'(m_pulse == 3));
      chk("candidatoNulo",    int'(candidatoNulo),    int'(m_pulse == 4));
      if (candidatoArthur)  pulse_cnt[0]++;
      if (candidatoLeandro) pulse_cnt[1]++;
      if (candidatoMateus)  pulse_cnt[2]++;
      if (candidatoPablo)   pulse_cnt[3]++;
      if (candidatoNulo)    pulse_cnt[4]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [3:0] d, input logic c, input int hold);
    @(negedge clock); #1;
    digit = d; confirma = c; valid = 1'b1;
    repeat (hold) @(negedge clock);
    #1 valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d, input logic conf_lvl);
    strobe(a, conf_lvl, 1);
    strobe(b, conf_lvl, 3);
    strobe(c, conf_lvl, 1);
    strobe(d, conf_lvl, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; digit = 4'd0; valid = 1'b0; confirma = 1'b0; finish = 1'b0;
    pulse_cnt = '{0, 0, 0, 0, 0};
    @(posedge clock);
    check_en = 1;
    // valid pulsed during reset, then held high across release
    @(negedge clock); #1 valid = 1'b1; digit = 4'd3;
    @(negedge clock); #1 valid = 1'b0;
    @(negedge clock); #1 valid = 1'b1;
    @(negedge clock); #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("lit_reset_estado", int'(estado), 0);
    chk("lit_reset_digito1", int'(digito1), 0);
    chk("lit_reset_voto", int'(votoValido), 0);

    // Arthur
    enter4(4'd3, 4'd5, 4'd0, 4'd3, 1'b0);
    chk("lit_arthur_conf", int'(estado), 4);
    chk("lit_arthur_voto", int'(votoValido), 1);
    strobe(4'd0, 1'b1, 1);
    chk("lit_arthur_back_d1", int'(estado), 0);
    chk("lit_arthur_cnt", pulse_cnt[0], 1);

    // Mateus with confirma held high during entry
    enter4(4'd3, 4'd5, 4'd1, 4'd3, 1'b1);
    chk("lit_mateus_digits", int'({digito1, digito2, digito3, digito4}), 16'h3513);
    strobe(4'd0, 1'b1, 1);
    chk("lit_mateus_cnt", pulse_cnt[2], 1);

    // Leandro, then a null code
    enter4(4'd3, 4'd4, 4'd8, 4'd9, 1'b0);
    strobe(4'd0, 1'b1, 1);
    chk("lit_leandro_cnt", pulse_cnt[1], 1);
    enter4(4'd3, 4'd4, 4'd8, 4'd0, 1'b0);
    chk("lit_nulo_voto", int'(votoValido), 2);
    strobe(4'd0, 1'b1, 1);
    chk("lit_nulo_cnt", pulse_cnt[4], 1);

    // Pablo, with a non-BCD digit in the middle of entry
    strobe(4'd3, 1'b0, 1);
    strobe(4'd5, 1'b0, 1);
    strobe(4'd11, 1'b0, 1);
    chk("lit_bad_digit_hold", int'(estado), 2);
    strobe(4'd2, 1'b0, 1);
    strobe(4'd7, 1'b0, 1);
    strobe(4'd0, 1'b1, 1);
    chk("lit_pablo_cnt", pulse_cnt[3], 1);

    // Cancel
    enter4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    strobe(4'd0, 1'b0, 1);
    chk("lit_cancel_estado", int'(estado), 0);
    chk("lit_cancel_digits", int'({digito1, digito2, digito3, digito4}), 0);
    chk("lit_cancel_voto", int'(votoValido), 0);
    strobe(4'd12, 1'b0, 1);
    chk("lit_digit12_ignored", int'(estado), 0);

    // Finish mid-entry
    strobe(4'd3, 1'b0, 1);
    strobe(4'd5, 1'b0, 1);
    @(negedge clock); #1 finish = 1'b1;
    @(negedge clock); #1 finish = 1'b0;
    @(negedge clock);
    chk("lit_done_estado", int'(estado), 6);
    chk("lit_done_voto", int'(votoValido), 3);
    enter4(4'd3, 4'd5, 4'd0, 4'd3, 1'b0);
    strobe(4'd0, 1'b1, 1);
    chk("lit_done_still", int'(estado), 6);
    chk("lit_done_no_pulse", pulse_cnt[0], 1);
    @(negedge clock); #1 reset = 1'b1;
    @(negedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("lit_reset_exit", int'(estado), 0);
    chk("lit_reset_exit_voto", int'(votoValido), 0);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
